// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the ALU stage and the data-memory access unit.
// The master drives load/store requests; the slave returns load data and status.
interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic                  mem_read;
   logic                  mem_write;
   logic [1:0]            size;
   logic                  load_unsigned;
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           write_data;
   logic [31:0]           read_data;
   logic                  busy;
   logic                  done;
   logic                  error;

   modport master (
      output start, mem_read, mem_write, size, load_unsigned, address, write_data,
      input  read_data, busy, done, error
   );

   modport slave (
      input  start, mem_read, mem_write, size, load_unsigned, address, write_data,
      output read_data, busy, done, error
   );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory stage: byte/half/word loads and stores on a word-wide synchronous RAM,
// sub-word stores by read-modify-write, sign/zero-extended loads, done/error reporting.
module mem_access_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   localparam int unsigned DEPTH = 1 << (ADDR_WIDTH - 2);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic [31:0]           wdata_q;
   logic                  uns_q;
   logic                  wr_q;
   logic                  error_q;
   logic [31:0]           merge_q;
   logic [31:0]           read_q;

   logic [31:0]           ram [DEPTH];
   logic [ADDR_WIDTH-3:0] word_idx;
   logic [31:0]           ram_word;
   logic [31:0]           shifted;
   logic [15:0]           half;
   logic [31:0]           load_val;
   logic [31:0]           store_word;
   logic                  accept;
   logic                  bad;

   assign word_idx = addr_q[ADDR_WIDTH-1:2];
   assign ram_word = ram[word_idx];
   assign shifted  = ram_word >> {addr_q[1:0], 3'b000};
   assign half     = addr_q[1] ? ram_word[31:16] : ram_word[15:0];

   always_comb begin
      load_val = ram_word;
      case (size_q)
         2'b00:   load_val = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_val = uns_q ? {16'b0, half} : {{16{half[15]}}, half};
         default: load_val = ram_word;
      endcase
   end

   // Sub-word stores overlay only the target lane onto the word captured in READ.
   always_comb begin
      store_word = merge_q;
      case (size_q)
         2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: store_word = wdata_q;
      endcase
   end

   assign accept = bus.start && (bus.mem_read || bus.mem_write) &&
                   (state == IDLE || state == DONE);
   assign bad    = (bus.mem_read && bus.mem_write) ||
                   (bus.size == 2'b11) ||
                   (bus.size == 2'b01 && bus.address[0]) ||
                   (bus.size == 2'b10 && bus.address[1:0] != 2'b00);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         wdata_q <= '0;
         uns_q   <= 1'b0;
         wr_q    <= 1'b0;
         error_q <= 1'b0;
         merge_q <= '0;
         read_q  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               error_q <= 1'b0;
               state   <= IDLE;
               if (accept) begin
                  addr_q  <= bus.address;
                  size_q  <= bus.size;
                  wdata_q <= bus.write_data;
                  uns_q   <= bus.load_unsigned;
                  wr_q    <= bus.mem_write;
                  if (bad) begin
                     state   <= DONE;
                     error_q <= 1'b1;
                  end else if (bus.mem_write && bus.size == 2'b10) begin
                     state <= WRITE;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (wr_q) begin
                  merge_q <= ram_word;
                  state   <= WRITE;
               end else begin
                  read_q <= load_val;
                  state  <= DONE;
               end
            end
            WRITE:   state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end

   // Reset forces state out of WRITE asynchronously, so no write can slip through.
   always_ff @(posedge clk) begin
      if (state == WRITE)
         ram[word_idx] <= store_word;
   end

   assign bus.busy      = (state == READ) || (state == WRITE);
   assign bus.done      = (state == DONE);
   assign bus.error     = error_q;
   assign bus.read_data = read_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// loads/stores compared against a word-array reference model.
module tb_mem_access_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_WIDTH(10)) bus ();
   mem_access_unit #(.ADDR_WIDTH(10)) dut (.clk(clk), .reset(reset), .bus(bus));

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model [256];
   logic [31:0] exp_rd = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issues one request (caller sits just after a rising edge) and checks the outcome.
   // poke keeps start high with scrambled inputs while the unit is busy.
   task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [9:0] a, input logic [31:0] wd, input bit poke);
      bit          err;
      int          k;
      int          exp_k;
      int          sh;
      logic [31:0] w;
      logic [31:0] m;
      logic [31:0] mask;
      err = (rd && wr) || sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
      bus.mem_read      = rd;
      bus.mem_write     = wr;
      bus.size          = sz;
      bus.load_unsigned = uns;
      bus.address       = a;
      bus.write_data    = wd;
      bus.start         = 1'b1;
      @(posedge clk); #1;
      if (poke && !err) begin
         bus.address       = 10'($urandom);
         bus.write_data    = $urandom;
         bus.size          = 2'($urandom);
         bus.mem_read      = 1'($urandom);
         bus.mem_write     = 1'($urandom);
         bus.load_unsigned = 1'($urandom);
      end else begin
         bus.start = 1'b0;
      end
      k = 0;
      while (!bus.done && k < 8) begin
         @(posedge clk); #1;
         k++;
      end
      bus.start = 1'b0;

      w  = model[a[9:2]];
      sh = 8 * int'(a[1:0]);
      if (err) begin
         exp_k = 0;
      end else if (rd) begin
         exp_k = 1;
         mask  = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
         m     = (sz == 2'b10) ? w : ((w >> sh) & mask);
         if (!uns && sz == 2'b00 && m[7])  m = m | 32'hFFFF_FF00;
         if (!uns && sz == 2'b01 && m[15]) m = m | 32'hFFFF_0000;
         exp_rd = m;
      end else if (sz == 2'b10) begin
         exp_k = 1;
         model[a[9:2]] = wd;
      end else begin
         exp_k = 2;
         mask  = (sz == 2'b00) ? 32'hFF : 32'hFFFF;
         model[a[9:2]] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      end
      check_eq("latency", 32'(k), 32'(exp_k));
      check_eq("error", 32'(bus.error), 32'(err));
      check_eq("busy_at_done", 32'(bus.busy), 32'd0);
      check_eq("read_data", bus.read_data, exp_rd);
   endtask

   initial begin
      bus.start = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b00;
      bus.load_unsigned = 1'b0; bus.address = '0; bus.write_data = '0;
      #12;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_error", 32'(bus.error), 32'd0);
      check_eq("rst_read_data", bus.read_data, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 256; i++)
         run_op(1'b0, 1'b1, 2'b10, 1'b0, 10'(i * 4), $urandom, 1'b0);

      // Word store then load
      run_op(1'b0, 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
      check_eq("plan_word", bus.read_data, 32'hDEADBEEF);

      // Byte store and extension
      run_op(1'b0, 1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 1'b0);
      run_op(1'b0, 1'b1, 2'b00, 1'b0, 10'h011, 32'h00000080, 1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
      check_eq("plan_byte_merge", bus.read_data, 32'h11228044);
      run_op(1'b1, 1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 1'b0);
      check_eq("plan_byte_signed", bus.read_data, 32'hFFFFFF80);
      run_op(1'b1, 1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 1'b0);
      check_eq("plan_byte_unsigned", bus.read_data, 32'h00000080);

      // Halfword lanes
      run_op(1'b0, 1'b1, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);
      run_op(1'b0, 1'b1, 2'b01, 1'b0, 10'h022, 32'h0000A5A5, 1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);
      check_eq("plan_half_word", bus.read_data, 32'hA5A50000);
      run_op(1'b1, 1'b0, 2'b01, 1'b0, 10'h022, 32'h0, 1'b0);
      check_eq("plan_half_signed", bus.read_data, 32'hFFFFA5A5);

      // Misalignment / illegal, then start-during-busy
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h013, 32'h0, 1'b0);
      run_op(1'b0, 1'b1, 2'b01, 1'b0, 10'h021, 32'hFFFF, 1'b0);
      run_op(1'b1, 1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 1'b0);
      run_op(1'b1, 1'b1, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
      run_op(1'b0, 1'b1, 2'b00, 1'b0, 10'h012, 32'h5A, 1'b1);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);

      // Request with neither read nor write is ignored
      bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("ignored_done", 32'(bus.done), 32'd0);
         check_eq("ignored_busy", 32'(bus.busy), 32'd0);
      end
      bus.start = 1'b0;

      // Reset during READ of a byte store
      bus.mem_read = 1'b0; bus.mem_write = 1'b1; bus.size = 2'b00;
      bus.address = 10'h030; bus.write_data = 32'hCC; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_eq("midrst_busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b0; #1;
      exp_rd = '0;
      check_eq("midrst_busy", 32'(bus.busy), 32'd0);
      check_eq("midrst_done", 32'(bus.done), 32'd0);
      check_eq("midrst_error", 32'(bus.error), 32'd0);
      check_eq("midrst_read_data", bus.read_data, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("midrst_no_done", 32'(bus.done), 32'd0);
      end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h030, 32'h0, 1'b0);

      // Back-to-back store then load in the DONE cycle
      run_op(1'b0, 1'b1, 2'b10, 1'b0, 10'h040, 32'h12345678, 1'b0);
      run_op(1'b1, 1'b0, 2'b10, 1'b0, 10'h040, 32'h0, 1'b0);
      check_eq("plan_b2b", bus.read_data, 32'h12345678);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int unsigned op;
         int unsigned gap;
         op  = $urandom_range(0, 9);
         gap = $urandom_range(0, 3);
         for (int g = 0; g < int'(gap); g++) begin
            @(posedge clk); #1;
         end
         run_op(op < 5, op == 0 || op >= 5, 2'($urandom), 1'($urandom),
                10'($urandom), $urandom, $urandom_range(0, 3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
